frame_rd_sched: RTL and testbench
=================================

Name: frame_rd_sched

Overview:
- Read-side scheduler for the paired header/payload dual-clock FIFOs in the MAC domain.
- Pops one header word (frame length), then pops exactly that many payload words.
- Delivers them as a framed valid/ready stream with SOP/EOP markers.
- Polices length and starvation, and keeps a frame counter for the RX control logic.

Parameters:
- MAX_LEN, 64: largest legal frame length in words (1..255).
- OBUF_DEPTH, 4: output buffer entries (>=2); also the payload read credit limit.
- TMO_CYC, 256: consecutive starved cycles mid-frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  MAC-domain clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush/restart.
- en  in  1  permits accepting new headers.
- hdr_empty  in  1  header FIFO empty.
- hdr_dout  in  8  header FIFO read data, valid the cycle after hdr_re.
- hdr_re  out  1  header FIFO pop.
- pld_empty  in  1  payload FIFO empty.
- pld_dout  in  8  payload FIFO read data, valid the cycle after pld_re.
- pld_re  out  1  payload FIFO pop.
- out_data  out  8  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_sop  out  1  first word of frame.
- out_eop  out  1  last word of frame.
- len_err  out  1  one-cycle pulse on an illegal header.
- tmo_err  out  1  sticky starvation abort flag.
- frame_cnt  out  16  frames delivered, wraps.
- busy  out  1  frame in progress, or data in flight or buffered.

Behaviour:
- Reset (rst=1, async): all outputs 0, state IDLE, buffer empty, counters 0.
- States: IDLE, HDR_WAIT, PLD, FLUSH, DRAIN, HALT.
- IDLE:
  - If en && !hdr_empty: hdr_re=1 for exactly one cycle, go to HDR_WAIT.
  - hdr_re is never asserted while hdr_empty=1.
- HDR_WAIT: latch L=hdr_dout.
  - L==0: len_err pulse, go to IDLE, no payload is read.
  - L>MAX_LEN: len_err pulse, go to FLUSH with remaining=L.
  - Otherwise: go to PLD with remaining=L.
- PLD and FLUSH:
  - pld_re=1 iff remaining>0 && !pld_empty && (occupancy + inflight) < OBUF_DEPTH.
  - Each pld_re decrements remaining.
  - Read data lands one cycle later.
  - In PLD it is written to the buffer tagged sop = first word of frame, eop = last word (L==1 sets both).
  - In FLUSH the data is discarded and the credit check is ignored.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: wait until inflight==0, then go to IDLE. The next header can be read while earlier words are still buffered.
- Output: out_valid = buffer non-empty; a word pops on out_valid && out_ready.
  - out_data, out_sop and out_eop are stable while out_valid && !out_ready.
  - Latency: pld_re to out_valid is 2 cycles when the buffer is empty.
  - Throughput is 1 word/cycle with out_ready high and OBUF_DEPTH>=3.
- frame_cnt: +1 on each popped word with out_eop=1; 0xFFFF wraps to 0. Flushed frames are not counted.
- Timeout: a starvation counter increments each cycle in PLD/FLUSH with remaining>0 && pld_empty, and clears otherwise.
  - At TMO_CYC: tmo_err=1, go to HALT.
  - HALT: hdr_re=pld_re=0; already-buffered words still drain; the partial frame is left without EOP.
  - Only clr or rst leaves HALT.
- en deassert mid-frame: the current frame completes; no new header is popped.
- clr (synchronous):
  - Go to IDLE, empty the buffer, clear remaining, inflight, tmo_err, frame_cnt and the starvation counter.
  - FIFO data arriving the cycle after clr is ignored.
  - hdr_re=pld_re=0 in the clr cycle.
- Simultaneous buffer push and pop in the same cycle: occupancy unchanged, both take effect.
- busy = state!=IDLE || inflight!=0 || occupancy!=0.

Decomposition:
- Package frame_rd_pkg:
  - state enum (6 states).
  - LEN_W=8, CNT_W=16.
  - Buffer entry typedef {sop, eop, data[7:0]}.
- One sub-module, sched_obuf:
  - synchronous FIFO of OBUF_DEPTH 10-bit entries.
  - exports occupancy count and supports flush.

Test Plan:
- Header 3, payloads A1 A2 A3, out_ready=1 -> A1(sop) A2 A3(eop) on consecutive cycles; frame_cnt=1; first out_valid 2 cycles after first pld_re.
- Header 1, payload 5C -> single word with sop=eop=1; header 0 -> len_err pulse, zero pld_re, frame_cnt unchanged.
- MAX_LEN=64, header 70 -> len_err pulse, exactly 70 pld_re, out_valid never asserted; a following header 2 frame is delivered normally.
- Backpressure: header 8, out_ready low -> at most OBUF_DEPTH(4) pops outstanding, out_data held; releasing ready delivers all 8 in order, EOP on word 8.
- TMO_CYC=16, header 4, only 2 payload words supplied -> tmo_err=1 after 16 starved cycles, 2 words delivered with no EOP, HALT; clr -> IDLE, tmo_err=0.
- clr on the cycle after pld_re -> returned data discarded, out_valid=0, frame_cnt=0; async rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/frame_rd_pkg.sv
// Shared types for the frame read scheduler.
//   state_t     : scheduler FSM states
//   obuf_ent_t  : output buffer entry {sop, eop, data}
//   LEN_W/CNT_W : header length and frame counter widths
package frame_rd_pkg;
   localparam int LEN_W = 8;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      HDR_WAIT,
      PLD,
      FLUSH,
      DRAIN,
      HALT
   } state_t;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [7:0] data;
   } obuf_ent_t;
endpackage

// File: rtl/frame_rd_sched_if.sv
// Bus bundle for frame_rd_sched: header FIFO read port, payload FIFO read
// port and the framed output stream.
//   master : the scheduler (pops FIFOs, drives the stream)
//   slave  : FIFO read side plus the stream sink
interface frame_rd_sched_if;
   logic       hdr_empty;
   logic [7:0] hdr_dout;
   logic       hdr_re;
   logic       pld_empty;
   logic [7:0] pld_dout;
   logic       pld_re;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_sop;
   logic       out_eop;

   modport master (
      input  hdr_empty, hdr_dout, pld_empty, pld_dout, out_ready,
      output hdr_re, pld_re, out_data, out_valid, out_sop, out_eop
   );

   modport slave (
      output hdr_empty, hdr_dout, pld_empty, pld_dout, out_ready,
      input  hdr_re, pld_re, out_data, out_valid, out_sop, out_eop
   );
endinterface

// File: rtl/sched_obuf.sv
// Small synchronous FIFO holding tagged output words.
//   clk, rst : clock, async active-high reset
//   flush    : synchronous empty
//   push/din : write one entry (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   dout     : head entry, zero while empty
//   empty    : no entries
//   occ      : current entry count
module sched_obuf
   import frame_rd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  obuf_ent_t                    din,
   input  logic                         pop,
   output obuf_ent_t                    dout,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   occ
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   obuf_ent_t      mem [DEPTH];
   logic [PW-1:0]  wp, rp;
   logic           do_push, do_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (occ == '0);
   assign do_push = push && (occ != OW'(DEPTH));
   assign do_pop  = pop && !empty;
   // Zeroed when empty so the stream reads 0 out of reset and after a flush.
   assign dout    = empty ? '0 : mem[rp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else begin
         if (do_push) wp <= adv(wp);
         if (do_pop)  rp <= adv(rp);
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/frame_rd_sched.sv
// Read-side scheduler for the paired header/payload FIFOs: pops a length
// header, then that many payload words, and emits them as a framed stream.
//   clk, rst  : MAC clock, async active-high reset
//   clr       : synchronous flush/restart
//   en        : allow popping new headers
//   bus       : header/payload FIFO read ports and output stream
//   len_err   : one-cycle pulse on a zero or oversize header
//   tmo_err   : sticky flag, payload starvation abort
//   frame_cnt : delivered frames (wraps)
//   busy      : frame in progress or words in flight/buffered
module frame_rd_sched
   import frame_rd_pkg::*;
#(
   parameter int MAX_LEN    = 64,
   parameter int OBUF_DEPTH = 4,
   parameter int TMO_CYC    = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   frame_rd_sched_if.master bus,
   output logic             len_err,
   output logic             tmo_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy
);
   localparam int OW = $clog2(OBUF_DEPTH + 1);
   localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

   state_t           state, state_nx;
   logic [LEN_W-1:0] rem, rem_nx;
   logic             first;                  // next payload read is the SOP word
   logic             infl, infl_keep, infl_sop, infl_eop;
   logic [TW-1:0]    starve;
   logic             hdr_re, pld_re, len_bad, tmo_hit, starved, credit_ok;

   obuf_ent_t        ob_din, ob_head;
   logic             ob_empty, ob_push, ob_pop;
   logic [OW-1:0]    ob_occ;

   // A read is only issued when its word is guaranteed a buffer slot.
   assign credit_ok = (int'(ob_occ) + int'(infl)) < OBUF_DEPTH;

   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      hdr_re   = 1'b0;
      pld_re   = 1'b0;
      len_bad  = 1'b0;
      tmo_hit  = 1'b0;
      starved  = 1'b0;
      case (state)
         IDLE: begin
            if (en && !bus.hdr_empty) begin
               hdr_re   = 1'b1;
               state_nx = HDR_WAIT;
            end
         end
         HDR_WAIT: begin
            if (bus.hdr_dout == '0) begin
               len_bad  = 1'b1;
               state_nx = IDLE;
            end else if (int'(bus.hdr_dout) > MAX_LEN) begin
               len_bad  = 1'b1;
               rem_nx   = bus.hdr_dout;
               state_nx = FLUSH;
            end else begin
               rem_nx   = bus.hdr_dout;
               state_nx = PLD;
            end
         end
         PLD, FLUSH: begin
            // Flushed words are discarded, so they need no buffer credit.
            pld_re  = (rem != '0) && !bus.pld_empty && ((state == FLUSH) || credit_ok);
            starved = (rem != '0) && bus.pld_empty;
            if (pld_re) begin
               rem_nx = rem - 1'b1;
               if (rem == LEN_W'(1)) state_nx = DRAIN;
            end
            if ((TMO_CYC != 0) && starved && (int'(starve) == TMO_CYC - 1)) begin
               tmo_hit  = 1'b1;
               state_nx = HALT;
            end
         end
         DRAIN: begin
            if (!infl) state_nx = IDLE;
         end
         default: ;   // HALT: only clr/rst leave
      endcase
      if (clr || rst) begin
         hdr_re = 1'b0;
         pld_re = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         first     <= 1'b0;
         infl      <= 1'b0;
         infl_keep <= 1'b0;
         infl_sop  <= 1'b0;
         infl_eop  <= 1'b0;
         starve    <= '0;
         len_err   <= 1'b0;
         tmo_err   <= 1'b0;
         frame_cnt <= '0;
      end else if (clr) begin
         state     <= IDLE;
         rem       <= '0;
         first     <= 1'b0;
         infl      <= 1'b0;
         infl_keep <= 1'b0;
         infl_sop  <= 1'b0;
         infl_eop  <= 1'b0;
         starve    <= '0;
         len_err   <= 1'b0;
         tmo_err   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nx;
         rem       <= rem_nx;
         len_err   <= len_bad;
         if (tmo_hit) tmo_err <= 1'b1;
         starve    <= starved ? starve + 1'b1 : '0;
         // Tags travel with the read so they line up with the returned data.
         infl      <= pld_re;
         infl_keep <= (state == PLD);
         infl_sop  <= first;
         infl_eop  <= (rem == LEN_W'(1));
         if (state == HDR_WAIT) first <= 1'b1;
         else if (pld_re)       first <= 1'b0;
         if (ob_pop && ob_head.eop) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   assign ob_din  = {infl_sop, infl_eop, bus.pld_dout};
   assign ob_push = infl && infl_keep && !clr;
   assign ob_pop  = !ob_empty && bus.out_ready;

   sched_obuf #(.DEPTH(OBUF_DEPTH)) u_obuf (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (ob_push),
      .din   (ob_din),
      .pop   (ob_pop),
      .dout  (ob_head),
      .empty (ob_empty),
      .occ   (ob_occ)
   );

   assign bus.hdr_re    = hdr_re;
   assign bus.pld_re    = pld_re;
   assign bus.out_valid = !ob_empty;
   assign bus.out_data  = ob_head.data;
   assign bus.out_sop   = ob_head.sop;
   assign bus.out_eop   = ob_head.eop;
   assign busy          = (state != IDLE) || infl || (ob_occ != '0);
endmodule

// File: tb/tb_frame_rd_sched.sv
// Bench for frame_rd_sched: behavioural header/payload FIFOs, a stream
// monitor, a table of single-frame vectors and hand-written corner sequences.
module tb_frame_rd_sched;
   import frame_rd_pkg::*;

   logic        clk = 1'b0;
   logic        rst, clr, en;
   logic        len_err, tmo_err, busy;
   logic [15:0] frame_cnt;

   frame_rd_sched_if bus ();

   frame_rd_sched #(.MAX_LEN(64), .OBUF_DEPTH(4), .TMO_CYC(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (en),
      .bus       (bus),
      .len_err   (len_err),
      .tmo_err   (tmo_err),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // FIFO models: data is valid the cycle after a pop
   logic [7:0] hmem [0:63];
   logic [7:0] pmem [0:1023];
   int hwr = 0, hrd = 0, pwr = 0, prd = 0;

   assign bus.hdr_empty = (hrd == hwr);
   assign bus.pld_empty = (prd == pwr);

   always @(posedge clk) begin
      if (bus.hdr_re) begin
         bus.hdr_dout <= hmem[hrd];
         hrd          <= hrd + 1;
      end
      if (bus.pld_re) begin
         bus.pld_dout <= pmem[prd];
         prd          <= prd + 1;
      end
   end

   // Monitor, sampled mid-cycle
   int         cyc = 0, nw = 0, npr = 0, nhr = 0, nle = 0, viol = 0, tmo_cyc = -1;
   int         pr_cyc [0:1023];
   int         w_cyc  [0:1023];
   logic [7:0] w_data [0:1023];
   logic       w_sop  [0:1023];
   logic       w_eop  [0:1023];
   logic       tmo_q = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            w_data[nw] <= bus.out_data;
            w_sop[nw]  <= bus.out_sop;
            w_eop[nw]  <= bus.out_eop;
            w_cyc[nw]  <= cyc;
            nw         <= nw + 1;
         end
         if (bus.pld_re) begin
            pr_cyc[npr] <= cyc;
            npr         <= npr + 1;
         end
         if (bus.hdr_re) nhr <= nhr + 1;
         if (bus.hdr_re && bus.hdr_empty) viol <= viol + 1;
         if (len_err) nle <= nle + 1;
         if (tmo_err && !tmo_q) tmo_cyc <= cyc;
         tmo_q <= tmo_err;
      end
   end

   int nchk = 0, nerr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_hdr(input logic [7:0] v);
      hmem[hwr] = v;
      hwr = hwr + 1;
   endtask

   task automatic push_pld(input logic [7:0] v);
      pmem[pwr] = v;
      pwr = pwr + 1;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (!((hrd == hwr) && !busy) && k < 2000) begin
         step();
         k++;
      end
      chk({nm, "_idle"}, int'(k < 2000), 1);
      repeat (3) step();
   endtask

   typedef struct {
      logic [7:0] len;
      logic [7:0] seed;
      int         npld;
      int         exp_words;
      int         exp_lerr;
      int         exp_inc;
   } vec_t;

   vec_t vt [7];

   initial begin
      int exp_fc, w0, p0, l0, h0, h1, k;

      vt[0] = '{8'd3,  8'hA1, 3,  3,  0, 1};
      vt[1] = '{8'd1,  8'h5C, 1,  1,  0, 1};
      vt[2] = '{8'd0,  8'h00, 0,  0,  1, 0};
      vt[3] = '{8'd70, 8'h00, 70, 0,  1, 0};
      vt[4] = '{8'd2,  8'h10, 2,  2,  0, 1};
      vt[5] = '{8'd64, 8'h80, 64, 64, 0, 1};
      vt[6] = '{8'd65, 8'h00, 65, 0,  1, 0};
      exp_fc = 0;

      rst = 1'b1; clr = 1'b0; en = 1'b0; bus.out_ready = 1'b0;
      repeat (3) step();
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fcnt", int'(frame_cnt), 0);
      chk("rst_tmo", int'(tmo_err), 0);
      chk("rst_lerr", int'(len_err), 0);
      rst = 1'b0; en = 1'b1; bus.out_ready = 1'b1;
      step();

      // single-frame vectors
      for (int i = 0; i < 7; i++) begin
         w0 = nw; p0 = npr; l0 = nle;
         for (int j = 0; j < vt[i].npld; j++) push_pld(8'(vt[i].seed + j));
         push_hdr(vt[i].len);
         wait_idle($sformatf("v%0d", i));
         exp_fc += vt[i].exp_inc;
         chk($sformatf("v%0d_words", i), nw - w0, vt[i].exp_words);
         chk($sformatf("v%0d_pldre", i), npr - p0, vt[i].npld);
         chk($sformatf("v%0d_lenerr", i), nle - l0, vt[i].exp_lerr);
         chk($sformatf("v%0d_fcnt", i), int'(frame_cnt), exp_fc);
         for (int j = 0; j < vt[i].exp_words && j < nw - w0; j++) begin
            chk($sformatf("v%0d_w%0d_data", i, j), int'(w_data[w0+j]), int'(8'(vt[i].seed + j)));
            chk($sformatf("v%0d_w%0d_sop", i, j), int'(w_sop[w0+j]), int'(j == 0));
            chk($sformatf("v%0d_w%0d_eop", i, j), int'(w_eop[w0+j]), int'(j == vt[i].exp_words - 1));
         end
         if (i == 0 && nw - w0 == 3) begin
            chk("v0_latency", w_cyc[w0] - pr_cyc[p0], 2);
            chk("v0_back2back", w_cyc[w0+2] - w_cyc[w0], 2);
         end
      end

      // backpressure, then en dropped mid-frame
      bus.out_ready = 1'b0;
      w0 = nw; p0 = npr;
      for (int j = 0; j < 8; j++) push_pld(8'(8'h30 + j));
      push_hdr(8'd8);
      repeat (30) step();
      chk("bp_credit", npr - p0, 4);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_sop", int'(bus.out_sop), 1);
      en = 1'b0;
      push_pld(8'h50); push_pld(8'h51);
      push_hdr(8'd2);
      h1 = nhr;
      for (int j = 0; j < 5; j++) begin
         step();
         chk($sformatf("bp_hold%0d", j), int'(bus.out_data), 8'h30);
      end
      bus.out_ready = 1'b1;
      k = 0;
      while (busy && k < 500) begin step(); k++; end
      chk("bp_drain", int'(k < 500), 1);
      repeat (5) step();
      chk("en_nohdr", nhr - h1, 0);
      chk("bp_words", nw - w0, 8);
      for (int j = 0; j < 8 && j < nw - w0; j++) begin
         chk($sformatf("bp_w%0d_data", j), int'(w_data[w0+j]), 8'h30 + j);
         chk($sformatf("bp_w%0d_eop", j), int'(w_eop[w0+j]), int'(j == 7));
      end
      exp_fc++;
      chk("bp_fcnt", int'(frame_cnt), exp_fc);
      en = 1'b1;
      w0 = nw;
      wait_idle("en_resume");
      exp_fc++;
      chk("en_words", nw - w0, 2);
      chk("en_w0", int'(w_data[w0]), 8'h50);
      chk("en_fcnt", int'(frame_cnt), exp_fc);

      // starvation timeout: header 4, only 2 payload words
      w0 = nw; p0 = npr;
      push_pld(8'h40); push_pld(8'h41);
      push_hdr(8'd4);
      k = 0;
      while (!tmo_err && k < 200) begin step(); k++; end
      chk("tmo_seen", int'(tmo_err), 1);
      repeat (2) step();
      chk("tmo_pldre", npr - p0, 2);
      if (npr - p0 == 2) chk("tmo_delay", tmo_cyc - pr_cyc[p0+1], 17);
      chk("tmo_words", nw - w0, 2);
      chk("tmo_sop", int'(w_sop[w0]), 1);
      chk("tmo_noeop0", int'(w_eop[w0]), 0);
      chk("tmo_noeop1", int'(w_eop[w0+1]), 0);
      chk("tmo_fcnt", int'(frame_cnt), exp_fc);
      chk("halt_busy", int'(busy), 1);
      push_pld(8'h77);
      push_hdr(8'd1);
      h0 = nhr;
      repeat (10) step();
      chk("halt_nohdr", nhr - h0, 0);
      chk("halt_sticky", int'(tmo_err), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_tmo", int'(tmo_err), 0);
      chk("clr_fcnt", int'(frame_cnt), 0);
      chk("clr_busy", int'(busy), 0);
      exp_fc = 0;
      w0 = nw;
      wait_idle("post_clr");
      exp_fc++;
      chk("pc_words", nw - w0, 1);
      chk("pc_data", int'(w_data[w0]), 8'h77);
      chk("pc_sopeop", int'({w_sop[w0], w_eop[w0]}), 3);
      chk("pc_fcnt", int'(frame_cnt), exp_fc);

      // clr in the cycle the first payload word returns
      w0 = nw;
      push_pld(8'h60); push_pld(8'h61); push_pld(8'h62);
      push_hdr(8'd3);
      k = 0;
      while (!bus.pld_re && k < 50) begin step(); k++; end
      chk("clr_found_re", int'(bus.pld_re), 1);
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("clr_novalid%0d", j), int'(bus.out_valid), 0);
         step();
      end
      chk("clr_words", nw - w0, 0);
      chk("clr2_fcnt", int'(frame_cnt), 0);
      chk("clr2_busy", int'(busy), 0);

      // async reset mid-frame (leftover payload words 61, 62 feed it)
      bus.out_ready = 1'b0;
      push_hdr(8'd2);
      k = 0;
      while (!bus.out_valid && k < 50) begin step(); k++; end
      chk("ar_valid_pre", int'(bus.out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", int'(bus.out_valid), 0);
      chk("ar_data", int'(bus.out_data), 0);
      chk("ar_sop", int'(bus.out_sop), 0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_re", int'({bus.hdr_re, bus.pld_re}), 0);
      chk("ar_fcnt", int'(frame_cnt), 0);
      step();
      rst = 1'b0;
      step();

      chk("hdr_re_while_empty", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
